// File: rtl/conv_output_packer_pkg.sv
// Shared definitions for the convolution output packer.
// Holds the default geometry constants, the FSM state encoding and the
// end-of-frame condition value that the controller also uses.
package conv_output_packer_pkg;

   localparam int unsigned CONV_DATA_W = 16;  // output word width (columns per row)
   localparam int unsigned CONV_ADDR_W = 12;  // SRAM address width
   localparam int unsigned CONV_COL_W  = 4;   // column index width

   // Kept identical to the controller's frame-end marker.
   localparam logic [15:0] END_CONDITION = 16'h00FF;

   typedef enum logic [1:0] {
      IDLE    = 2'b00,
      COLLECT = 2'b01,
      FLUSH   = 2'b10,
      DONE    = 2'b11
   } state_t;

endpackage

// File: rtl/conv_output_packer_fsm.sv
// Frame-level control for the output packer.
// Ports:
//   clk_i, rst_i         clock, asynchronous active-high reset
//   start_i              begin a new frame (honoured only in IDLE)
//   in_valid_i           pixel beat valid
//   frame_last_i         beat is the last pixel of the frame
//   state_o              current state
//   busy_o               high from the cycle after start until DONE ends
//   done_o               one-cycle pulse after the final word write
//   err_drop_o           sticky: a beat arrived outside COLLECT
module packer_fsm
   import conv_output_packer_pkg::*;
(
   input  logic   clk_i,
   input  logic   rst_i,
   input  logic   start_i,
   input  logic   in_valid_i,
   input  logic   frame_last_i,
   output state_t state_o,
   output logic   busy_o,
   output logic   done_o,
   output logic   err_drop_o
);

   state_t state_q, state_d;
   logic   err_drop_q, err_drop_d;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q    <= IDLE;
         err_drop_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         err_drop_q <= err_drop_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      err_drop_d = err_drop_q;
      busy_o     = 1'b0;
      done_o     = 1'b0;
      case (state_q)
         IDLE: begin
            if (start_i) begin
               state_d    = COLLECT;
               err_drop_d = 1'b0;
            end
         end
         COLLECT: begin
            busy_o = 1'b1;
            if (in_valid_i && frame_last_i) state_d = FLUSH;
         end
         FLUSH: begin
            busy_o  = 1'b1;
            state_d = DONE;
         end
         DONE: begin
            busy_o  = 1'b1;
            done_o  = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
      // A stray beat outranks the clear from a coincident start.
      if (in_valid_i && (state_q != COLLECT)) err_drop_d = 1'b1;
   end

   assign state_o    = state_q;
   assign err_drop_o = err_drop_q;

endmodule

// File: rtl/conv_output_packer.sv
// Write-back stage of the binary 3x3 convolution pipeline.
// Packs one output pixel per beat into DATA_W-bit row words (column 0 in the
// MSB) and issues one single-cycle SRAM write per row.
// Ports:
//   clk, reset_b          clock, asynchronous active-high reset
//   start                 one-cycle pulse: begin a new frame
//   in_valid/in_pixel     pixel beat and its value
//   in_col/in_waddr       column within row, SRAM address of the row
//   in_row_last           last beat of the row (forces a write)
//   in_frame_last         last beat of the frame (also forces a write)
//   dut_sram_write_*      SRAM write port (address/data hold between strobes)
//   busy, done            frame status
//   words_written         saturating count of words written this frame
//   err_drop              sticky: a beat arrived while not collecting
module conv_output_packer
   import conv_output_packer_pkg::*;
#(
   parameter int unsigned DATA_W = CONV_DATA_W,
   parameter int unsigned ADDR_W = CONV_ADDR_W,
   parameter int unsigned COL_W  = CONV_COL_W
) (
   input  logic              clk,
   input  logic              reset_b,
   input  logic              start,
   input  logic              in_valid,
   input  logic              in_pixel,
   input  logic [COL_W-1:0]  in_col,
   input  logic [ADDR_W-1:0] in_waddr,
   input  logic              in_row_last,
   input  logic              in_frame_last,
   output logic [ADDR_W-1:0] dut_sram_write_address,
   output logic [DATA_W-1:0] dut_sram_write_data,
   output logic              dut_sram_write_enable,
   output logic              busy,
   output logic              done,
   output logic [ADDR_W-1:0] words_written,
   output logic              err_drop
);

   state_t state;

   logic [DATA_W-1:0] acc_q, acc_d, acc_beat;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic [ADDR_W-1:0] waddr_q, waddr_d;
   logic [ADDR_W-1:0] ww_q, ww_d;
   logic              we_q, we_d;

   packer_fsm u_fsm (
      .clk_i        (clk),
      .rst_i        (reset_b),
      .start_i      (start),
      .in_valid_i   (in_valid),
      .frame_last_i (in_frame_last),
      .state_o      (state),
      .busy_o       (busy),
      .done_o       (done),
      .err_drop_o   (err_drop)
   );

   // Accumulator with the current beat merged in; column c lands on bit DATA_W-1-c.
   always_comb begin
      acc_beat = acc_q;
      for (int unsigned i = 0; i < DATA_W; i++) begin
         if (COL_W'(DATA_W - 1 - i) == in_col) acc_beat[i] = in_pixel;
      end
   end

   always_comb begin
      acc_d   = acc_q;
      wdata_d = wdata_q;
      waddr_d = waddr_q;
      ww_d    = ww_q;
      we_d    = 1'b0;
      if ((state == IDLE) && start) begin
         acc_d = '0;
         ww_d  = '0;
      end else if ((state == COLLECT) && in_valid) begin
         if (in_row_last || in_frame_last) begin
            // Word leaves with this beat's bit; accumulator restarts for the next row.
            we_d    = 1'b1;
            wdata_d = acc_beat;
            waddr_d = in_waddr;
            acc_d   = '0;
            if (ww_q != '1) ww_d = ww_q + ADDR_W'(1);
         end else begin
            acc_d = acc_beat;
         end
      end
   end

   always_ff @(posedge clk or posedge reset_b) begin
      if (reset_b) begin
         acc_q   <= '0;
         wdata_q <= '0;
         waddr_q <= '0;
         ww_q    <= '0;
         we_q    <= 1'b0;
      end else begin
         acc_q   <= acc_d;
         wdata_q <= wdata_d;
         waddr_q <= waddr_d;
         ww_q    <= ww_d;
         we_q    <= we_d;
      end
   end

   assign dut_sram_write_address = waddr_q;
   assign dut_sram_write_data    = wdata_q;
   assign dut_sram_write_enable  = we_q;
   assign words_written          = ww_q;

endmodule

// File: tb/tb_conv_output_packer.sv
module tb_conv_output_packer;

   logic        clk = 1'b0;
   logic        reset_b;
   logic        start;
   logic        in_valid;
   logic        in_pixel;
   logic [3:0]  in_col;
   logic [11:0] in_waddr;
   logic        in_row_last;
   logic        in_frame_last;
   logic [11:0] waddr;
   logic [15:0] wdata;
   logic        we;
   logic        busy;
   logic        done;
   logic [11:0] ww;
   logic        err_drop;

   int vectors = 0;
   int miscompares = 0;

   always #5 clk = ~clk;

   conv_output_packer #(.DATA_W(16), .ADDR_W(12), .COL_W(4)) dut (
      .clk                    (clk),
      .reset_b                (reset_b),
      .start                  (start),
      .in_valid               (in_valid),
      .in_pixel               (in_pixel),
      .in_col                 (in_col),
      .in_waddr               (in_waddr),
      .in_row_last            (in_row_last),
      .in_frame_last          (in_frame_last),
      .dut_sram_write_address (waddr),
      .dut_sram_write_data    (wdata),
      .dut_sram_write_enable  (we),
      .busy                   (busy),
      .done                   (done),
      .words_written          (ww),
      .err_drop               (err_drop)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Advance to just after the next rising edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_inputs();
      start         = 1'b0;
      in_valid      = 1'b0;
      in_pixel      = 1'b0;
      in_col        = 4'd0;
      in_waddr      = 12'h000;
      in_row_last   = 1'b0;
      in_frame_last = 1'b0;
   endtask

   task automatic drive(input logic p, input logic [3:0] c, input logic [11:0] a,
                        input logic rl, input logic fl);
      in_valid      = 1'b1;
      in_pixel      = p;
      in_col        = c;
      in_waddr      = a;
      in_row_last   = rl;
      in_frame_last = fl;
   endtask

   // One beat across one clock edge; inputs return to idle afterwards.
   task automatic beat(input logic p, input logic [3:0] c, input logic [11:0] a,
                       input logic rl, input logic fl);
      drive(p, c, a, rl, fl);
      step();
      clear_inputs();
   endtask

   task automatic pulse_start();
      start = 1'b1;
      step();
      start = 1'b0;
   endtask

   task automatic chk_write(input string tag, input logic [11:0] a, input logic [15:0] d,
                            input logic [11:0] n);
      chk({tag, ".we"},   32'(we),    32'd1);
      chk({tag, ".addr"}, 32'(waddr), 32'(a));
      chk({tag, ".data"}, 32'(wdata), 32'(d));
      chk({tag, ".ww"},   32'(ww),    32'(n));
   endtask

   initial begin
      clear_inputs();
      reset_b = 1'b0;
      #2 reset_b = 1'b1;
      step();
      step();
      chk("rst.we",       32'(we),       32'd0);
      chk("rst.busy",     32'(busy),     32'd0);
      chk("rst.done",     32'(done),     32'd0);
      chk("rst.ww",       32'(ww),       32'd0);
      chk("rst.err_drop", 32'(err_drop), 32'd0);
      chk("rst.addr",     32'(waddr),    32'd0);
      chk("rst.data",     32'(wdata),    32'd0);
      reset_b = 1'b0;
      step();

      // Frame 1: 14-column alternating row.
      pulse_start();
      chk("start.busy", 32'(busy), 32'd1);
      for (int c = 0; c < 14; c++) begin
         beat(((c % 2) == 0), 4'(c), 12'h010, (c == 13), 1'b0);
         if (c < 13) chk("row1.nowe", 32'(we), 32'd0);
      end
      chk_write("row1", 12'h010, 16'hAAA8, 12'd1);
      step();
      chk("row1.we_low",    32'(we),    32'd0);
      chk("row1.addr_hold", 32'(waddr), 32'h010);
      chk("row1.data_hold", 32'(wdata), 32'hAAA8);

      // Two rows ending on consecutive cycles.
      beat(1'b1, 4'd0, 12'h020, 1'b0, 1'b0);
      drive(1'b1, 4'd1, 12'h020, 1'b1, 1'b0);
      step();
      chk_write("rowA", 12'h020, 16'hC000, 12'd2);
      drive(1'b1, 4'd0, 12'h021, 1'b1, 1'b0);
      step();
      clear_inputs();
      chk_write("rowB", 12'h021, 16'h8000, 12'd3);
      step();
      chk("rowB.we_low", 32'(we), 32'd0);

      // Five beats accumulated, then reset lands before a pending row write.
      for (int c = 0; c < 5; c++) beat(1'b1, 4'(c), 12'h022, 1'b0, 1'b0);
      drive(1'b1, 4'd5, 12'h022, 1'b1, 1'b0);
      #3 reset_b = 1'b1;
      #1;
      chk("arst.we",   32'(we),    32'd0);
      chk("arst.busy", 32'(busy),  32'd0);
      chk("arst.ww",   32'(ww),    32'd0);
      chk("arst.addr", 32'(waddr), 32'd0);
      chk("arst.data", 32'(wdata), 32'd0);
      step();
      chk("arst.no_strobe", 32'(we), 32'd0);
      clear_inputs();
      reset_b = 1'b0;
      step();
      chk("arst.idle", 32'(busy), 32'd0);

      // Frame 2: start ignored mid-COLLECT; frame_last closes the partial row.
      pulse_start();
      beat(1'b1, 4'd3, 12'h030, 1'b1, 1'b0);
      chk_write("f2row0", 12'h030, 16'h1000, 12'd1);
      beat(1'b1, 4'd0, 12'h031, 1'b0, 1'b0);
      pulse_start();
      chk("midstart.ww",   32'(ww),   32'd1);
      chk("midstart.busy", 32'(busy), 32'd1);
      chk("midstart.we",   32'(we),   32'd0);
      beat(1'b1, 4'd15, 12'h031, 1'b0, 1'b1);
      chk_write("f2last", 12'h031, 16'h8001, 12'd2);
      chk("flush.busy", 32'(busy), 32'd1);
      chk("flush.done", 32'(done), 32'd0);
      beat(1'b0, 4'd2, 12'h0FF, 1'b1, 1'b0);  // stray beat during FLUSH
      chk("done.pulse", 32'(done),     32'd1);
      chk("done.we",    32'(we),       32'd0);
      chk("flush.drop", 32'(err_drop), 32'd1);
      step();
      chk("post.done", 32'(done), 32'd0);
      chk("post.busy", 32'(busy), 32'd0);

      // Beat in IDLE: dropped, sticky error until next start.
      beat(1'b1, 4'd0, 12'h050, 1'b1, 1'b0);
      chk("idle.we",   32'(we),       32'd0);
      chk("idle.drop", 32'(err_drop), 32'd1);
      chk("idle.ww",   32'(ww),       32'd2);
      step();
      chk("idle.drop_sticky", 32'(err_drop), 32'd1);
      pulse_start();
      chk("f3.drop_clr", 32'(err_drop), 32'd0);
      chk("f3.ww_clr",   32'(ww),       32'd0);

      // Frame 3: only column 15 written, with frame_last.
      beat(1'b1, 4'd15, 12'h040, 1'b0, 1'b1);
      chk_write("f3", 12'h040, 16'h0001, 12'd1);
      step();
      chk("f3.done", 32'(done), 32'd1);
      chk("f3.we",   32'(we),   32'd0);
      step();
      chk("f3.done_end", 32'(done), 32'd0);
      chk("f3.busy",     32'(busy), 32'd0);
      chk("f3.ww_final", 32'(ww),   32'd1);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
